hand_code_encoder: RTL
======================

// Module: hand_code_encoder
// PURPOSE
//  Front end that produces the 2-bit hand code consumed by the LED gesture-unlock FSM.
//  - Samples two raw proximity-sensor inputs and synchronises them to clk.
//  - Debounces the pair as one 2-bit word.
//  - Publishes a stable code with a one-cycle change strobe.
//  - Sits between board pins and the gesture FSM; one clock domain.
// PARAMETERS
//  DEBOUNCE_CYCLES    1_000_000  cycles a new code must hold before commit (>=1; 10 ms @100 MHz)
//  SENSOR_ACTIVE_LOW  1          1: raw pin low = hand present; 0: raw pin high = hand present
// PORTS
//  clk         in   1  system clock, rising edge
//  rst_n       in   1  asynchronous, active-low reset
//  sens_l_raw  in   1  left sensor pin, asynchronous to clk
//  sens_r_raw  in   1  right sensor pin, asynchronous to clk
//  hand        out  2  debounced code: bit0 = left present, bit1 = right present (00/01/10/11)
//  hand_chg    out  1  one-cycle pulse, high in the first cycle hand holds a new value
//  stable      out  1  high when no candidate code is settling
//  glitch_cnt  out  8  aborted-settle count (only with HAND_GLITCH_CNT_EN)
// BEHAVIOUR
//  Reset (async assert, sync release): hand=00, hand_chg=0, stable=1, glitch_cnt=0, state=STABLE.
//    Sync flops reset to the inactive pin level; no spurious change after release.
//  Sync: 2 flops per channel, then polarity per SENSOR_ACTIVE_LOW -> present code s[1:0].
//  Counter: width $clog2(DEBOUNCE_CYCLES)+1; holds candidate cand[1:0].
//  FSM states STABLE, SETTLE:
//   STABLE: s==hand -> stay. s!=hand -> cand<=s, cnt<=0, go SETTLE.
//   SETTLE (checks in priority order):
//     1. s==hand: abort to STABLE; this is a glitch.
//     2. s!=cand, s!=hand: cand<=s, cnt<=0, stay in SETTLE.
//     3. cnt==DEBOUNCE_CYCLES-1: hand<=cand, hand_chg<=1, go STABLE.
//     4. Otherwise cnt<=cnt+1.
//  Latency: new pin level first sampled at edge k -> hand updates at edge k+2+DEBOUNCE_CYCLES.
//    hand_chg is high for exactly that following cycle.
//  hand only ever takes codes held for a full debounce window. No intermediate code is published.
//  stable = (state==STABLE), registered-state decode.
//  Both channels changing on different cycles: each change restarts the window (rule 2).
//  Reset mid-SETTLE: candidate discarded, hand=00 immediately.
//    After release, a held code needs the full 2+DEBOUNCE_CYCLES latency.
// CONFIGURATION
//  HAND_GLITCH_CNT_EN defined:
//   - glitch_cnt port exists.
//   - Increments by 1 on each SETTLE abort (rule 1); saturates at 255.
//   - Cleared only by rst_n.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Package hand_pkg: state enum {STABLE, SETTLE}.
//    Code constants HAND_NONE=2'b00, HAND_LEFT=2'b01, HAND_RIGHT=2'b10, HAND_BOTH=2'b11.
//    The gesture FSM shares these constants.
//  Sub-module sync_2ff: one 2-flop synchroniser with reset value parameter; instantiated twice.
//  Debounce counter and FSM stay in this module.
// TESTING (DEBOUNCE_CYCLES=4, SENSOR_ACTIVE_LOW=1)
//  1. Hold rst_n=0 with pins toggling -> hand=00, hand_chg=0, stable=1, glitch_cnt=0 throughout.
//  2. Both pins low from edge k -> hand=11 at edge k+6; hand_chg high 1 cycle; stable low edges k+2..k+5.
//  3. Left pin low for 3 cycles, then high -> hand stays 00, no hand_chg, glitch_cnt=1.
//  4. Both low, then right high 2 cycles later -> hand goes 00->01 directly, never 11.
//     Commit at 2+4 edges after the right-high edge.
//  5. Assert rst_n mid-SETTLE -> hand=00, stable=1 asynchronously.
//     Release with pins held -> hand commits 6 edges after the first sampling edge.
//  6. Sequence 11,01,11,00, each held 10 cycles -> exactly four hand_chg pulses.
//     hand reads 11,01,11,00 in order, each committed 6 edges after its pin change.

Source files
------------

// File: rtl/hand_code_encoder_pkg.sv
// Shared hand-code definitions for the proximity front end and the gesture FSM.
// Package name is hand_pkg so downstream blocks can import the same constants.
package hand_pkg;

  // Debounce FSM states
  typedef enum logic {
    STABLE = 1'b0,
    SETTLE = 1'b1
  } hand_state_e;

  // Hand codes: bit0 = left present, bit1 = right present
  localparam logic [1:0] HAND_NONE  = 2'b00;
  localparam logic [1:0] HAND_LEFT  = 2'b01;
  localparam logic [1:0] HAND_RIGHT = 2'b10;
  localparam logic [1:0] HAND_BOTH  = 2'b11;

  // Turn synchronised pin levels into a presence code for the given polarity
  function automatic logic [1:0] hand_decode(input logic pin_l,
                                             input logic pin_r,
                                             input logic active_low);
    logic [1:0] code;
    if (active_low) begin
      code = {~pin_r, ~pin_l};
    end else begin
      code = {pin_r, pin_l};
    end
    return code;
  endfunction

endpackage

// File: rtl/hand_code_encoder_sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
// RESET_VAL lets the caller park the chain at the pin's idle level so that
// reset release does not look like a transition.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  // Next-state of the two-stage chain
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, reset to the idle pin level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/hand_code_encoder.sv
// Hand code encoder: synchronises the left/right proximity pins, debounces
// them as one 2-bit word and publishes the committed code with a change strobe.
// Optional feature macro: HAND_GLITCH_CNT_EN adds the 8-bit glitch_cnt port
// counting aborted settle windows (saturating, cleared only by rst_n).
module hand_code_encoder
  import hand_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
  parameter bit          SENSOR_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sens_l_raw,
  input  logic       sens_r_raw,
  output logic [1:0] hand,
  output logic       hand_chg,
  output logic       stable
`ifdef HAND_GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt
`endif
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Idle (hand absent) pin level: high for active-low sensors
  localparam bit               PIN_IDLE = SENSOR_ACTIVE_LOW;

  logic        sens_l_sync_s;
  logic        sens_r_sync_s;
  logic [1:0]  pres_s;

  hand_state_e      state_d, state_q;
  logic [1:0]       cand_d, cand_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [1:0]       hand_d, hand_q;
  logic             hand_chg_d, hand_chg_q;
  logic             stable_d, stable_q;

  sync_2ff #(.RESET_VAL(PIN_IDLE)) u_sync_l (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sens_l_raw),
    .q     (sens_l_sync_s)
  );

  sync_2ff #(.RESET_VAL(PIN_IDLE)) u_sync_r (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sens_r_raw),
    .q     (sens_r_sync_s)
  );

  assign pres_s = hand_decode(sens_l_sync_s, sens_r_sync_s, SENSOR_ACTIVE_LOW);

  // Debounce FSM next-state: a candidate must hold for a full window to commit
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    cnt_d      = cnt_q;
    hand_d     = hand_q;
    hand_chg_d = 1'b0;
    case (state_q)
      STABLE: begin
        if (pres_s != hand_q) begin
          cand_d  = pres_s;
          cnt_d   = '0;
          state_d = SETTLE;
        end else begin
          state_d = STABLE;
        end
      end
      SETTLE: begin
        if (pres_s == hand_q) begin
          // Input fell back to the published code: drop the candidate
          state_d = STABLE;
        end else if (pres_s != cand_q) begin
          // A different code appeared: restart the window on it
          cand_d = pres_s;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          hand_d     = cand_q;
          hand_chg_d = 1'b1;
          state_d    = STABLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE;
      end
    endcase
    stable_d = (state_d == STABLE);
  end

  // Debounce state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= STABLE;
      cand_q     <= HAND_NONE;
      cnt_q      <= '0;
      hand_q     <= HAND_NONE;
      hand_chg_q <= 1'b0;
      stable_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      cnt_q      <= cnt_d;
      hand_q     <= hand_d;
      hand_chg_q <= hand_chg_d;
      stable_q   <= stable_d;
    end
  end

  assign hand     = hand_q;
  assign hand_chg = hand_chg_q;
  assign stable   = stable_q;

`ifdef HAND_GLITCH_CNT_EN
  logic       abort_s;
  logic [7:0] glitch_d, glitch_q;

  // Count settle windows abandoned because the input returned to the published code
  always_comb begin
    abort_s = (state_q == SETTLE) && (pres_s == hand_q);
    if (abort_s && (glitch_q != 8'hFF)) begin
      glitch_d = glitch_q + 8'd1;
    end else begin
      glitch_d = glitch_q;
    end
  end

  // Glitch counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`endif

endmodule
